// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-port core-memory arbiter.
//   state_e  - arbiter FSM states
//   AW_DEF   - default address width (18-bit PDP-6 address)
//   DW_DEF   - default data word width (36 bits)
//   GNT_*    - one-hot grant encodings, GNT_NONE while idle
package mem_arb_pkg;

    localparam int AW_DEF = 18;
    localparam int DW_DEF = 36;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        WAIT = 2'd2
    } state_e;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_P0   = 2'b01;
    localparam logic [1:0] GNT_P1   = 2'b10;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: combinational two-way round-robin pick.
//   req_i  - request vector, bit n = port n requesting
//   last_i - index of the port granted last time (pointer kept by the parent)
//   gnt_o  - one-hot grant, GNT_NONE when nobody requests
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = GNT_NONE;
        unique case (req_i)
            2'b01:   gnt_o = GNT_P0;
            2'b10:   gnt_o = GNT_P1;
            // Tie goes to whichever port did not win last time.
            2'b11:   gnt_o = last_i ? GNT_P0 : GNT_P1;
            default: gnt_o = GNT_NONE;
        endcase
    end

endmodule

// File: rtl/mem_arbiter_2p.sv
// mem_arbiter_2p: shares one core memory between the processor bus (port 0)
// and the console/DMA loader (port 1).
//   i_clk, i_reset_n             - clock, async active-low reset
//   i_sN_address/read/write/...  - master port N request side
//   o_sN_readdata/waitrequest    - master port N response side
//   o_m_*, i_m_*                 - memory side
//   o_grant                      - one-hot current grant (00 when idle), debug
//
// state | meaning
// IDLE  | no strobes driven; arbitrate and latch grant on any request
// ADDR  | present granted port to memory for one clock, memory wait ignored
// WAIT  | hold drive; complete when memory drops waitrequest
module mem_arbiter_2p
    import mem_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          i_clk,
    input  logic          i_reset_n,

    input  logic [AW-1:0] i_s0_address,
    input  logic          i_s0_read,
    input  logic          i_s0_write,
    input  logic [DW-1:0] i_s0_writedata,
    output logic [DW-1:0] o_s0_readdata,
    output logic          o_s0_waitrequest,

    input  logic [AW-1:0] i_s1_address,
    input  logic          i_s1_read,
    input  logic          i_s1_write,
    input  logic [DW-1:0] i_s1_writedata,
    output logic [DW-1:0] o_s1_readdata,
    output logic          o_s1_waitrequest,

    output logic [AW-1:0] o_m_address,
    output logic          o_m_read,
    output logic          o_m_write,
    output logic [DW-1:0] o_m_writedata,
    input  logic [DW-1:0] i_m_readdata,
    input  logic          i_m_waitrequest,

    output logic [1:0]    o_grant
);

    state_e     state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic       ptr_q, ptr_d;
    logic [1:0] req;
    logic [1:0] gnt_rr;
    logic       granted_req;
    logic       sel_p1;

    assign req         = {i_s1_read | i_s1_write, i_s0_read | i_s0_write};
    assign sel_p1      = (grant_q == GNT_P1);
    assign granted_req = sel_p1 ? req[1] : req[0];

    rr_arbiter2 u_rr (
        .req_i  (req),
        .last_i (ptr_q),
        .gnt_o  (gnt_rr)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            grant_q <= GNT_NONE;
            ptr_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = ADDR;
                    grant_d = gnt_rr;
                    ptr_d   = gnt_rr[1];
                end
            end
            // A dropped request abandons the transfer without completion.
            ADDR: state_d = granted_req ? WAIT : IDLE;
            WAIT: begin
                if (!granted_req || !i_m_waitrequest) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_m_address   = '0;
        o_m_read      = 1'b0;
        o_m_write     = 1'b0;
        o_m_writedata = '0;
        o_grant       = GNT_NONE;
        if (state_q == ADDR || state_q == WAIT) begin
            o_grant = grant_q;
            if (sel_p1) begin
                o_m_address   = i_s1_address;
                o_m_writedata = i_s1_writedata;
                o_m_write     = i_s1_write;
                o_m_read      = i_s1_read & ~i_s1_write;
            end else begin
                o_m_address   = i_s0_address;
                o_m_writedata = i_s0_writedata;
                o_m_write     = i_s0_write;
                o_m_read      = i_s0_read & ~i_s0_write;
            end
        end
    end

    assign o_s0_waitrequest = ~(state_q == WAIT && grant_q == GNT_P0 && !i_m_waitrequest);
    assign o_s1_waitrequest = ~(state_q == WAIT && grant_q == GNT_P1 && !i_m_waitrequest);

    assign o_s0_readdata = i_m_readdata;
    assign o_s1_readdata = i_m_readdata;

endmodule

// File: tb/tb_mem_arbiter_2p.sv
module tb_mem_arbiter_2p;
    import mem_arb_pkg::*;

    localparam int AW = 18;
    localparam int DW = 36;

    logic          i_clk = 1'b0;
    logic          i_reset_n;
    logic [AW-1:0] i_s0_address, i_s1_address;
    logic          i_s0_read, i_s0_write, i_s1_read, i_s1_write;
    logic [DW-1:0] i_s0_writedata, i_s1_writedata;
    logic [DW-1:0] o_s0_readdata, o_s1_readdata;
    logic          o_s0_waitrequest, o_s1_waitrequest;
    logic [AW-1:0] o_m_address;
    logic          o_m_read, o_m_write;
    logic [DW-1:0] o_m_writedata;
    logic [DW-1:0] i_m_readdata;
    logic          i_m_waitrequest;
    logic [1:0]    o_grant;

    always #5 i_clk = ~i_clk;

    mem_arbiter_2p #(.AW(AW), .DW(DW)) dut (
        .i_clk            (i_clk),
        .i_reset_n        (i_reset_n),
        .i_s0_address     (i_s0_address),
        .i_s0_read        (i_s0_read),
        .i_s0_write       (i_s0_write),
        .i_s0_writedata   (i_s0_writedata),
        .o_s0_readdata    (o_s0_readdata),
        .o_s0_waitrequest (o_s0_waitrequest),
        .i_s1_address     (i_s1_address),
        .i_s1_read        (i_s1_read),
        .i_s1_write       (i_s1_write),
        .i_s1_writedata   (i_s1_writedata),
        .o_s1_readdata    (o_s1_readdata),
        .o_s1_waitrequest (o_s1_waitrequest),
        .o_m_address      (o_m_address),
        .o_m_read         (o_m_read),
        .o_m_write        (o_m_write),
        .o_m_writedata    (o_m_writedata),
        .i_m_readdata     (i_m_readdata),
        .i_m_waitrequest  (i_m_waitrequest),
        .o_grant          (o_grant)
    );

    // Reference memory: 32K words, registered waitrequest that drops for the
    // clock after a strobe is first seen and re-arms after completion.
    logic [DW-1:0] mem [0:32767];
    logic          mwait_q = 1'b1;
    logic          hold_wait;
    logic          in_range;

    assign in_range        = (o_m_address[AW-1:15] == '0);
    assign i_m_waitrequest = hold_wait | mwait_q;
    assign i_m_readdata    = in_range ? mem[o_m_address[14:0]] : '0;

    always @(posedge i_clk) begin
        if (o_m_write && !i_m_waitrequest && in_range)
            mem[o_m_address[14:0]] = o_m_writedata;
        mwait_q <= !((o_m_read || o_m_write) && i_m_waitrequest);
    end

    typedef struct {
        bit            is_rd;
        logic [DW-1:0] data;
    } sb_t;

    sb_t sb0[$];
    sb_t sb1[$];
    int  done_port[$];
    int  n_cmp = 0;
    int  n_err = 0;
    int  n_s0_done = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0o expected %0o", tag, got, exp);
        end
    endtask

    // Completion monitor: pops the scoreboard on every waitrequest-low cycle.
    always @(negedge i_clk) begin
        sb_t e;
        if (i_reset_n) begin
            if (!o_s0_waitrequest) begin
                n_s0_done++;
                chk("s0_done_grant", 64'(o_grant), 64'(GNT_P0));
                if (sb0.size() == 0) chk("s0_spurious_done", 64'(sb0.size()), 64'(1));
                else begin
                    e = sb0.pop_front();
                    if (e.is_rd) chk("s0_rdata", 64'(o_s0_readdata), 64'(e.data));
                    done_port.push_back(0);
                end
            end
            if (!o_s1_waitrequest) begin
                chk("s1_done_grant", 64'(o_grant), 64'(GNT_P1));
                if (sb1.size() == 0) chk("s1_spurious_done", 64'(sb1.size()), 64'(1));
                else begin
                    e = sb1.pop_front();
                    if (e.is_rd) chk("s1_rdata", 64'(o_s1_readdata), 64'(e.data));
                    done_port.push_back(1);
                end
            end
        end
    end

    // Call at posedge+1; cyc is the clock index (0 = first cycle seen) of completion.
    task automatic xfer(input int port, input bit rd, input bit wr,
                        input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input logic [DW-1:0] exp_rd,
                        output int cyc, output logic m_rd, output logic m_wr);
        sb_t e;
        bit  done;
        e.is_rd = rd & ~wr;
        e.data  = exp_rd;
        cyc  = -1;
        m_rd = 1'b0;
        m_wr = 1'b0;
        done = 1'b0;
        if (port == 0) begin
            sb0.push_back(e);
            i_s0_address = a; i_s0_writedata = wd; i_s0_read = rd; i_s0_write = wr;
        end else begin
            sb1.push_back(e);
            i_s1_address = a; i_s1_writedata = wd; i_s1_read = rd; i_s1_write = wr;
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge i_clk);
            if ((port == 0) ? !o_s0_waitrequest : !o_s1_waitrequest) begin
                cyc  = i;
                m_rd = o_m_read;
                m_wr = o_m_write;
                done = 1'b1;
                break;
            end
        end
        chk("xfer_completed", 64'(done), 64'(1));
        @(posedge i_clk);
        #1;
        if (port == 0) begin i_s0_read = 1'b0; i_s0_write = 1'b0; end
        else           begin i_s1_read = 1'b0; i_s1_write = 1'b0; end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int       cyc, cyc_a, cyc_b, s0_before;
        logic     m_rd, m_wr;
        int       exp_order[4];
        exp_order = '{0, 1, 0, 1};

        for (int i = 0; i < 32768; i++) mem[i] = '0;
        mem[0]  = 36'o777000111222;
        mem[8]  = 36'o111111111111;
        mem[16] = 36'o222222222222;

        i_reset_n = 1'b0;
        hold_wait = 1'b0;
        i_s0_address = '0; i_s0_read = 1'b0; i_s0_write = 1'b0; i_s0_writedata = '0;
        i_s1_address = '0; i_s1_read = 1'b0; i_s1_write = 1'b0; i_s1_writedata = '0;
        #2;
        chk("rst_m_read",   64'(o_m_read),         64'(0));
        chk("rst_m_write",  64'(o_m_write),        64'(0));
        chk("rst_m_addr",   64'(o_m_address),      64'(0));
        chk("rst_m_wdata",  64'(o_m_writedata),    64'(0));
        chk("rst_grant",    64'(o_grant),          64'(0));
        chk("rst_s0_wait",  64'(o_s0_waitrequest), 64'(1));
        chk("rst_s1_wait",  64'(o_s1_waitrequest), 64'(1));
        repeat (2) @(posedge i_clk);
        #1 i_reset_n = 1'b1;

        // Memory holds waitrequest: arbiter parks in WAIT, then reset mid-WAIT.
        hold_wait = 1'b1;
        @(posedge i_clk); #1;
        i_s0_address = 18'o000010; i_s0_read = 1'b1;
        repeat (7) @(negedge i_clk);
        chk("hold_m_read", 64'(o_m_read), 64'(1));
        chk("hold_grant",  64'(o_grant),  64'(GNT_P0));
        #1 i_reset_n = 1'b0;
        #1;
        chk("midwait_rst_m_read",  64'(o_m_read),         64'(0));
        chk("midwait_rst_m_write", 64'(o_m_write),        64'(0));
        chk("midwait_rst_grant",   64'(o_grant),          64'(0));
        chk("midwait_rst_s0_wait", 64'(o_s0_waitrequest), 64'(1));
        chk("midwait_rst_s1_wait", 64'(o_s1_waitrequest), 64'(1));
        i_s0_read = 1'b0;
        hold_wait = 1'b0;
        @(posedge i_clk); #1 i_reset_n = 1'b1;
        @(posedge i_clk); #1;

        // Both ports read continuously: first tie to port 0, then strict alternation.
        done_port.delete();
        cyc_a = -1;
        fork
            begin
                int c; logic r, w;
                xfer(0, 1, 0, 18'o000010, '0, 36'o111111111111, c, r, w);
                cyc_a = c;
                xfer(0, 1, 0, 18'o000010, '0, 36'o111111111111, c, r, w);
            end
            begin
                int c; logic r, w;
                xfer(1, 1, 0, 18'o000020, '0, 36'o222222222222, c, r, w);
                xfer(1, 1, 0, 18'o000020, '0, 36'o222222222222, c, r, w);
            end
        join
        chk("tie_first_cyc", 64'(cyc_a), 64'(2));
        chk("alt_count", 64'(done_port.size()), 64'(4));
        for (int i = 0; i < 4 && i < done_port.size(); i++)
            chk($sformatf("alt_order[%0d]", i), 64'(done_port[i]), 64'(exp_order[i]));

        // Port 0 write then read back.
        xfer(0, 0, 1, 18'o000100, 36'o0123456701, '0, cyc, m_rd, m_wr);
        chk("wr_cyc", 64'(cyc), 64'(2));
        chk("wr_strobe", 64'({m_rd, m_wr}), 64'(2'b01));
        xfer(0, 1, 0, 18'o000100, '0, 36'o0123456701, cyc, m_rd, m_wr);
        chk("rd_cyc", 64'(cyc), 64'(2));
        chk("rd_strobe", 64'({m_rd, m_wr}), 64'(2'b10));

        // Port 1 read+write together is a write.
        xfer(1, 1, 1, 18'o077777, 36'o555444333222, '0, cyc, m_rd, m_wr);
        chk("rw_cyc", 64'(cyc), 64'(2));
        chk("rw_m_read", 64'(m_rd), 64'(0));
        chk("rw_m_write", 64'(m_wr), 64'(1));
        xfer(1, 1, 0, 18'o077777, '0, 36'o555444333222, cyc, m_rd, m_wr);
        chk("rw_readback_cyc", 64'(cyc), 64'(2));

        // Out-of-range write completes normally and does not alias to word 0.
        xfer(0, 0, 1, 18'o200000, 36'o123123123123, '0, cyc, m_rd, m_wr);
        chk("oor_cyc", 64'(cyc), 64'(3 - 1));
        chk("oor_mem0", 64'(mem[0]), 64'(36'o777000111222));
        xfer(0, 1, 0, 18'o000000, '0, 36'o777000111222, cyc, m_rd, m_wr);
        chk("oor_read0_cyc", 64'(cyc), 64'(2));

        // Port 0 drops read during ADDR; pending port 1 request is served next.
        s0_before = n_s0_done;
        i_s0_address = 18'o000010; i_s0_read = 1'b1;
        @(posedge i_clk); #1;
        chk("drop_grant_addr", 64'(o_grant), 64'(GNT_P0));
        i_s0_read = 1'b0;
        xfer(1, 1, 0, 18'o000020, '0, 36'o222222222222, cyc, m_rd, m_wr);
        chk("drop_s1_cyc", 64'(cyc), 64'(3));
        chk("drop_no_s0_done", 64'(n_s0_done - s0_before), 64'(0));

        repeat (3) @(posedge i_clk);
        chk("sb0_empty", 64'(sb0.size()), 64'(0));
        chk("sb1_empty", 64'(sb1.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
